// File: rtl/anyedge_delay_checker_if.sv
//------------------------------------------------------------------------------
// Module      : anyedge_delay_checker_if
// Description : Trigger/qualifier/config and result bundle for the checker.
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface anyedge_delay_checker_if #(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 8
);
  logic [CNT_W-1:0]    cfg_delay;
  logic [CHANNELS-1:0] exp_pre;
  logic [CHANNELS-1:0] exp_post;
  logic [CHANNELS-1:0] trig;
  logic [CHANNELS-1:0] qual;
  logic [CHANNELS-1:0] busy;
  logic [CHANNELS-1:0] done;
  logic [CHANNELS-1:0] pass;
  logic [CNT_W-1:0]    err_count;
  logic [CHANNELS-1:0] overrun;

  modport master (
    output cfg_delay, exp_pre, exp_post, trig, qual,
    input  busy, done, pass, err_count, overrun
  );

  modport slave (
    input  cfg_delay, exp_pre, exp_post, trig, qual,
    output busy, done, pass, err_count, overrun
  );
endinterface

`default_nettype wire

// File: rtl/anyedge_delay_checker.sv
//------------------------------------------------------------------------------
// Module      : anyedge_delay_checker
// Description : Per-channel any-edge triggered pre/post qualifier checker with
//               saturating error count. Define ANYEDGE_OVERRUN_EN for overrun
//               detection and check restart on edges during WAIT.
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module anyedge_delay_checker #(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  anyedge_delay_checker_if.slave  bus
);

  localparam int c_SUM_W = $clog2(2 * CHANNELS + 1);
  localparam int c_ACC_W = CNT_W + c_SUM_W;
  localparam logic [c_ACC_W-1:0] c_ERR_MAX = c_ACC_W'({CNT_W{1'b1}});

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  logic                r_armed;
  logic [CHANNELS-1:0] r_trig_q;
  logic [CNT_W-1:0]    r_err;
  logic [CHANNELS-1:0] w_fail;
  logic [CHANNELS-1:0] w_ovr_evt;
  logic [c_SUM_W-1:0]  w_inc;
  logic [c_ACC_W-1:0]  w_err_sum;
  logic [CNT_W-1:0]    w_err_nxt;
  logic [CNT_W-1:0]    w_load;

  // A zero delay still needs one cycle to take the post sample.
  assign w_load = (bus.cfg_delay == '0) ? CNT_W'(1) : bus.cfg_delay;

  // The first cycle after reset only captures trig levels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_armed  <= 1'b0;
      r_trig_q <= '0;
    end else begin
      r_armed  <= 1'b1;
      r_trig_q <= bus.trig;
    end
  end

  genvar i;
  for (i = 0; i < CHANNELS; i++) begin : g_ch
    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_pre_ok, w_pre_ok_nxt;
    logic             r_exp_post, w_exp_post_nxt;
    logic             r_done, w_done_nxt;
    logic             r_pass, w_pass_nxt;
    logic             w_edge, w_start, w_ovr;

    assign w_edge = r_armed & (bus.trig[i] ^ r_trig_q[i]);

    always_comb begin
      w_state_nxt    = r_state;
      w_cnt_nxt      = r_cnt;
      w_pre_ok_nxt   = r_pre_ok;
      w_exp_post_nxt = r_exp_post;
      w_done_nxt     = 1'b0;
      w_pass_nxt     = 1'b0;
      w_start        = 1'b0;
      w_ovr          = 1'b0;
      case (r_state)
        ST_IDLE: w_start = w_edge;
        ST_WAIT: begin
`ifdef ANYEDGE_OVERRUN_EN
          if (w_edge) begin
            w_start = 1'b1;
            w_ovr   = 1'b1;
          end else
`endif
          if (r_cnt == CNT_W'(1)) begin
            w_done_nxt  = 1'b1;
            w_pass_nxt  = r_pre_ok & (bus.qual[i] == r_exp_post);
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
      if (w_start) begin
        w_state_nxt    = ST_WAIT;
        w_cnt_nxt      = w_load;
        w_pre_ok_nxt   = (bus.qual[i] == bus.exp_pre[i]);
        w_exp_post_nxt = bus.exp_post[i];
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_state    <= ST_IDLE;
        r_cnt      <= '0;
        r_pre_ok   <= 1'b0;
        r_exp_post <= 1'b0;
        r_done     <= 1'b0;
        r_pass     <= 1'b0;
      end else begin
        r_state    <= w_state_nxt;
        r_cnt      <= w_cnt_nxt;
        r_pre_ok   <= w_pre_ok_nxt;
        r_exp_post <= w_exp_post_nxt;
        r_done     <= w_done_nxt;
        r_pass     <= w_pass_nxt;
      end
    end

    assign bus.busy[i] = (r_state == ST_WAIT);
    assign bus.done[i] = r_done;
    assign bus.pass[i] = r_pass;
    assign w_fail[i]    = w_done_nxt & ~w_pass_nxt;
    assign w_ovr_evt[i] = w_ovr;

`ifdef ANYEDGE_OVERRUN_EN
    logic r_overrun;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_overrun <= 1'b0;
      end else if (w_ovr) begin
        r_overrun <= 1'b1;
      end
    end
    assign bus.overrun[i] = r_overrun;
`else
    assign bus.overrun[i] = 1'b0;
`endif
  end

  always_comb begin
    w_inc = '0;
    for (int j = 0; j < CHANNELS; j++) begin
      w_inc = w_inc + c_SUM_W'(w_fail[j]) + c_SUM_W'(w_ovr_evt[j]);
    end
    w_err_sum = c_ACC_W'(r_err) + c_ACC_W'(w_inc);
    w_err_nxt = (w_err_sum > c_ERR_MAX) ? {CNT_W{1'b1}} : w_err_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= '0;
    end else begin
      r_err <= w_err_nxt;
    end
  end

  assign bus.err_count = r_err;

endmodule

`default_nettype wire

// File: tb/tb_anyedge_delay_checker.sv
//------------------------------------------------------------------------------
// Module      : tb_anyedge_delay_checker
// Description : Directed self-checking bench for anyedge_delay_checker.
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_anyedge_delay_checker;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  anyedge_delay_checker_if #(.CHANNELS(4), .CNT_W(8)) bus ();

  anyedge_delay_checker #(.CHANNELS(4), .CNT_W(8)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Caller has just passed the edge clock k; done is required exactly at k+n.
  task automatic wait_done(input string tag, input int ch, input int n, input logic exp_pass);
    int early;
    early = 0;
    for (int j = 1; j < n; j++) begin
      tick();
      if (bus.done[ch]) early++;
    end
    check_eq({tag, " early_done"}, early, 0);
    tick();
    check_eq({tag, " done"}, 32'(bus.done[ch]), 1);
    check_eq({tag, " pass"}, 32'(bus.pass[ch]), 32'(exp_pass));
  endtask

  initial begin
    int cnt;
    rst_n         = 1'b0;
    bus.trig      = 4'b1111;
    bus.qual      = 4'b0000;
    bus.exp_pre   = 4'b0000;
    bus.exp_post  = 4'b0000;
    bus.cfg_delay = 8'd0;
    repeat (3) tick();
    check_eq("rst busy", 32'(bus.busy), 0);
    check_eq("rst done", 32'(bus.done), 0);
    check_eq("rst pass", 32'(bus.pass), 0);
    check_eq("rst err", 32'(bus.err_count), 0);
    check_eq("rst overrun", 32'(bus.overrun), 0);

    // Static high trig levels at release must not start checks.
    rst_n = 1'b1;
    cnt = 0;
    for (int j = 0; j < 10; j++) begin
      tick();
      if (bus.busy != 4'b0 || bus.done != 4'b0) cnt++;
    end
    check_eq("release quiet", cnt, 0);

    // Passing check, qualifier rises mid-wait, delay 25.
    bus.cfg_delay = 8'd25;
    bus.exp_post  = 4'b0001;
    bus.trig[0]   = ~bus.trig[0];
    tick();
    check_eq("d25 busy", 32'(bus.busy[0]), 1);
    cnt = 0;
    for (int j = 1; j < 25; j++) begin
      tick();
      if (j == 10) bus.qual[0] = 1'b1;
      if (bus.done[0]) cnt++;
    end
    check_eq("d25 early_done", cnt, 0);
    tick();
    check_eq("d25 done", 32'(bus.done[0]), 1);
    check_eq("d25 pass", 32'(bus.pass[0]), 1);
    check_eq("d25 err", 32'(bus.err_count), 0);
    check_eq("d25 busy_end", 32'(bus.busy[0]), 0);
    tick();
    check_eq("d25 done_pulse", 32'(bus.done[0]), 0);
    check_eq("d25 pass_low", 32'(bus.pass[0]), 0);

    // Failing check: qualifier never reaches expected post value.
    bus.qual[0] = 1'b0;
    bus.trig[0] = ~bus.trig[0];
    tick();
    wait_done("fail", 0, 25, 1'b0);
    check_eq("fail err", 32'(bus.err_count), 1);

    // Zero delay behaves as one cycle.
    bus.cfg_delay = 8'd0;
    bus.trig[2]   = ~bus.trig[2];
    tick();
    wait_done("d0", 2, 1, 1'b1);
    check_eq("d0 err", 32'(bus.err_count), 1);

    // Second edge five cycles into a ten-cycle check.
    bus.cfg_delay = 8'd10;
    bus.trig[1]   = ~bus.trig[1];
    tick();
    repeat (4) tick();
    bus.trig[1] = ~bus.trig[1];
    tick();
`ifdef ANYEDGE_OVERRUN_EN
    check_eq("ovr flag", 32'(bus.overrun[1]), 1);
    check_eq("ovr err", 32'(bus.err_count), 2);
    wait_done("ovr", 1, 10, 1'b1);
`else
    check_eq("ovr flag", 32'(bus.overrun[1]), 0);
    wait_done("ovr", 1, 5, 1'b1);
    check_eq("ovr err", 32'(bus.err_count), 1);
`endif
    cnt = 0;
    for (int j = 0; j < 12; j++) begin
      tick();
      if (bus.done[1] || bus.busy[1]) cnt++;
    end
    check_eq("ovr single_done", cnt, 0);

    // Reset during a wait aborts immediately.
    bus.trig[3] = ~bus.trig[3];
    tick();
    repeat (2) tick();
    rst_n = 1'b0;
    #1;
    check_eq("abort busy", 32'(bus.busy), 0);
    check_eq("abort done", 32'(bus.done), 0);
    check_eq("abort err", 32'(bus.err_count), 0);
    check_eq("abort overrun", 32'(bus.overrun), 0);
    repeat (2) tick();
    rst_n = 1'b1;
    cnt = 0;
    for (int j = 0; j < 15; j++) begin
      tick();
      if (bus.done != 4'b0 || bus.busy != 4'b0) cnt++;
    end
    check_eq("abort quiet", cnt, 0);

    // Error counter saturation over 300 failing checks.
    bus.cfg_delay = 8'd1;
    bus.exp_post  = 4'b0001;
    bus.qual      = 4'b0000;
    for (int n = 1; n <= 300; n++) begin
      bus.trig[0] = ~bus.trig[0];
      tick();
      tick();
      if (n == 1) begin
        check_eq("sat done", 32'(bus.done[0]), 1);
        check_eq("sat pass", 32'(bus.pass[0]), 0);
      end
      if (n == 254) check_eq("sat err254", 32'(bus.err_count), 254);
      if (n == 255) check_eq("sat err255", 32'(bus.err_count), 255);
    end
    check_eq("sat hold", 32'(bus.err_count), 255);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/anyedge_delay_checker.md
# anyedge_delay_checker

Multi-channel, synthesizable any-edge delayed checker for the dynamic-scheduler test benches. Each channel watches a trigger line for any edge, samples a qualifier immediately and again a programmable number of clock cycles later, then reports pass/fail. It replaces hand-written `always @(x) ... #N check` processes with a clocked, parametrised block, and adds per-channel expected values, error counting and overrun handling.

## Interface
- CHANNELS, 4, number of independent trigger/qualifier channels (1..32)
- CNT_W, 8, width of delay counter and error counter
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- cfg_delay  in  CNT_W  cycles between pre-check and post-check; shared by all channels, sampled at the trigger edge
- exp_pre  in  CHANNELS  expected qualifier value at the trigger edge, per channel
- exp_post  in  CHANNELS  expected qualifier value at the post-check, per channel
- trig  in  CHANNELS  trigger lines; any edge (0->1 or 1->0) starts a check
- qual  in  CHANNELS  qualifier lines under check
- busy  out  CHANNELS  channel is in WAIT
- done  out  CHANNELS  one-cycle pulse: check complete
- pass  out  CHANNELS  valid with done: both samples matched
- err_count  out  CNT_W  saturating count of failed checks, all channels
- overrun  out  CHANNELS  sticky: edge arrived while channel was busy (macro only, else tied 0)

## Operation
- Per channel: registered trig_q; edge = trig[i] ^ trig_q[i] while global `armed` = 1.
- `armed` resets to 0, sets on first clock after reset release; during that cycle trig_q loads without edge detection, so static levels at reset release never trigger.
- States per channel: IDLE, WAIT.
- IDLE + edge at clock k: pre_ok <= (qual[i] == exp_pre[i]); cnt <= max(cfg_delay,1); post expectation latched from exp_post[i]; -> WAIT.
- WAIT: cnt decrements each clock; on clock where cnt == 1: post_ok = (qual[i] == latched exp_post); done[i] <= 1; pass[i] <= pre_ok & post_ok; -> IDLE.
- cfg_delay = 0 is treated as 1.
- err_count increments by number of channels failing on the same clock; saturates at 2^CNT_W-1, never wraps.
- Edges in WAIT: see Configuration.
- pass is 0 whenever done is 0.

## Timing
- Reset values: busy=0, done=0, pass=0, err_count=0, overrun=0, all channels IDLE, trig_q=0, armed=0.
- Trigger edge sampled at clock k; post-check sample at clock k+D (D=max(cfg_delay,1)); done/pass visible from k+D until k+D+1.
- busy high from k to k+D (inclusive of the cycle after k, low after k+D).
- New edge detected at clock k+D+1 or later starts a fresh check; an edge at clock k+D counts as during WAIT.
- err_count updates on the same clock as the failing done.
- Reset asserted mid-WAIT: channel aborts to IDLE immediately, no done pulse, err_count cleared.
- cfg_delay/exp_post changes during WAIT do not affect an in-flight check.

## Configuration
- ANYEDGE_OVERRUN_EN defined: edge during WAIT sets overrun[i] (sticky until reset), counts one error in err_count, and restarts the check as if from IDLE (new pre-sample, counter reloaded); no done for the aborted check.
- Not defined: edges during WAIT are ignored (trig_q still tracks), overrun tied to 0.

## Test plan
- Reset release with trig=4'b1111 -> no busy, no done for 10 cycles.
- cfg_delay=25, exp_pre=0, exp_post=1; toggle trig[0] with qual[0]=0, set qual[0]=1 at k+10 -> done[0]=pass[0]=1 exactly at k+25, err_count=0.
- Same but qual[0] stays 0 -> done[0]=1, pass[0]=0, err_count=1; repeat 300 times with CNT_W=8 -> err_count holds 255.
- cfg_delay=0, edge on trig[2] -> done[2] one cycle after edge clock.
- Edge trig[1] at k, again at k+5, cfg_delay=10: with macro -> overrun[1]=1, err_count=1, single done at k+15; without -> done at k+10, overrun=0.
- rst_n low at k+3 of a 10-cycle check -> outputs zero immediately, no done after release.
